simple_cic_ctl: RTL
===================

Name: simple_cic_ctl

Overview:
Sequencer and output buffer for one simple_cic decimator instance. It owns the CIC's reset and input gate (g_in). It generates input strobes at a programmable rate, flushes and re-settles the filter on every rate change, and discards transient outputs. Valid outputs are buffered in a small FIFO with a valid/ready stream interface toward the downstream consumer, with sticky overrun reporting.

Parameters:
DW, 18, CIC output width (matches simple_cic d_out)
CNT_W, 12, width of rate divider and cfg_rate
FLUSH_CYC, 4, cycles cic_reset is held in FLUSH (1..15)
SETTLE_N, 3, g_out pulses discarded after flush (0..15)
FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
enable  in  1  run request; level-sensitive
cfg_rate  in  CNT_W  input strobe period minus one
cfg_stb  in  1  one-cycle pulse: latch cfg_rate
clr_overrun  in  1  one-cycle pulse: clear overrun
cic_reset  out  1  drives simple_cic reset, active-high
cic_g_in  out  1  drives simple_cic g_in
cic_g_out  in  1  simple_cic g_out
cic_d_out  in  DW  simple_cic d_out, signed
m_valid  out  1  FIFO non-empty
m_ready  in  1  consumer accepts m_data when m_valid&m_ready
m_data  out  DW  FIFO head, signed
overrun  out  1  sticky: a RUN-state sample was dropped
busy  out  1  state != IDLE

Behaviour:
Reset (reset_n low, async):
- Outputs: cic_reset=1, cic_g_in=0, m_valid=0, m_data=0, overrun=0, busy=0.
- Internal: state=IDLE, rate_q=0, FIFO empty.
- Reset mid-operation: immediate return to these values; nothing is retained.

States: IDLE, FLUSH, SETTLE, RUN. All outputs are registered.
- IDLE: cic_reset=1, cic_g_in=0. cfg_stb latches rate_q. enable=1 -> FLUSH.
- FLUSH: cic_reset=1 for exactly FLUSH_CYC cycles. FIFO is cleared on entry. Rate divider is loaded with 0 on exit -> SETTLE.
- SETTLE: cic_reset=0. Discard counter counts g_out pulses. After SETTLE_N pulses -> RUN. With SETTLE_N=0, go straight to RUN on the cycle after FLUSH.
- RUN: each g_out pulse pushes cic_d_out into the FIFO.
- cfg_stb in FLUSH/SETTLE/RUN: latch cfg_rate into rate_q and re-enter FLUSH (restart FLUSH count and clear FIFO).
- enable=0 in any non-IDLE state: next state IDLE. FIFO contents are retained and drainable.
- cfg_stb and enable falling in the same cycle: rate is latched, next state is IDLE.

Rate divider (active in SETTLE and RUN):
- cic_g_in=1 when divider==0; the divider then reloads rate_q, otherwise decrements.
- rate_q=0 gives a strobe every cycle; rate_q=R gives one strobe every R+1 cycles.
- The first strobe occurs on the first SETTLE cycle.
- cic_g_in=0 in IDLE and FLUSH.

FIFO (depth 2**FIFO_AW):
- Push when state==RUN and cic_g_out. Pop when m_valid&m_ready.
- m_valid/m_data reflect the head. There is no bypass: a push into an empty FIFO gives m_valid=1 on the next cycle (1-cycle latency).
- Full with push and no pop: sample dropped, overrun set.
- Full with simultaneous push and pop: both occur, no overrun.
- Empty with pop is impossible, since m_valid=0.
- Pointers wrap modulo depth; an extra count bit distinguishes full from empty.
- m_data holds its last value while m_valid=0.

overrun:
- Set on a drop; cleared by clr_overrun.
- If set and clear occur in the same cycle, set wins.
- Not cleared by FLUSH.

Test Plan:
- Reset and enable: reset_n low 3 cycles -> all outputs at reset values. Then with enable=1 and default rate_q=0: busy=1, cic_reset=1 for 4 cycles, then cic_g_in=1 every cycle.
- Rate and settle: cfg_rate=3, cfg_stb, enable; CIC model emits g_out one cycle after each g_in with data 100,101,... -> cic_g_in on every 4th cycle; first 3 outputs discarded; m_data sequence 103,104,105 with m_valid 1 cycle after each g_out.
- Backpressure and overrun: m_ready=0, rate 0, RUN -> m_valid=1; 4 samples stored; 5th dropped, overrun=1. m_ready=1 drains exactly the first 4 values in order. clr_overrun -> overrun=0.
- Full with simultaneous push/pop: FIFO full, m_ready=1 on the same cycle as g_out -> count stays 4, overrun stays 0, new value appears at the tail.
- Mid-run reconfig: in RUN with 2 samples queued, cfg_stb with cfg_rate=1 -> FIFO empty next cycle, 4-cycle flush, 3 discards, then strobes every 2 cycles.
- Disable and async reset: enable=0 in RUN with 3 queued -> IDLE, busy=0, cic_reset=1, all 3 still drainable. reset_n pulsed mid-SETTLE (not clock-aligned) -> outputs return to reset values immediately.

Source files
------------

// File: rtl/simple_cic_ctl.sv
// Sequencer plus output FIFO for one simple_cic decimator: owns its reset and g_in, flushes and re-settles on rate change.
// Latency: a RUN-state g_out sample appears on m_valid/m_data one cycle after the pulse (no bypass path).
// Backpressure: m_ready low lets the FIFO fill; a sample arriving while full with no pop is dropped and sets sticky overrun.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   enable                  level run request; low returns to IDLE, FIFO kept
//   cfg_rate, cfg_stb       strobe period minus one, latched on cfg_stb (restarts the flush when running)
//   clr_overrun             clears the sticky overrun flag (a same-cycle drop wins)
//   cic_reset, cic_g_in     drive the CIC reset and input gate
//   cic_g_out, cic_d_out    CIC output strobe and data
//   m_valid, m_ready, m_data  downstream valid/ready stream (FIFO head)
//   overrun, busy           status
module simple_cic_ctl #(
    parameter int DW        = 18,
    parameter int CNT_W     = 12,
    parameter int FLUSH_CYC = 4,
    parameter int SETTLE_N  = 3,
    parameter int FIFO_AW   = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [CNT_W-1:0] cfg_rate,
    input  logic             cfg_stb,
    input  logic             clr_overrun,
    output logic             cic_reset,
    output logic             cic_g_in,
    input  logic             cic_g_out,
    input  logic [DW-1:0]    cic_d_out,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DW-1:0]    m_data,
    output logic             overrun,
    output logic             busy
);

    localparam int         DEPTH       = 2**FIFO_AW;
    localparam logic [3:0] FLUSH_LOAD  = 4'(FLUSH_CYC - 1);
    // Only used when SETTLE_N > 0; the SETTLE_N == 0 case skips SETTLE entirely.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_N - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_SETTLE,
        ST_RUN
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rate_q, rate_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [3:0]       flush_q, flush_d;
    logic [3:0]       settle_q, settle_d;
    logic             flush_entry;
    logic             strobe;

    // FIFO storage and pointers; the extra MSB separates full from empty.
    logic [DW-1:0]      mem_q [DEPTH];
    logic [FIFO_AW:0]   wr_q, rd_q;
    logic [FIFO_AW-1:0] wr_idx, rd_idx;
    logic [DW-1:0]      hold_q;
    logic               overrun_q;
    logic               fifo_empty, fifo_full;
    logic               push_req, push, pop, drop;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    assign strobe = (div_q == '0);

    always_comb begin
        state_d     = state_q;
        rate_d      = rate_q;
        div_d       = div_q;
        flush_d     = flush_q;
        settle_d    = settle_q;
        flush_entry = 1'b0;

        // The rate is latched in every state, even when enable drops together with cfg_stb.
        if (cfg_stb) begin
            rate_d = cfg_rate;
        end

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    flush_entry = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (flush_q == '0) begin
                    // Divider starts at zero so the first SETTLE cycle strobes.
                    div_d    = '0;
                    settle_d = '0;
                    state_d  = (SETTLE_N == 0) ? ST_RUN : ST_SETTLE;
                end else begin
                    flush_d = flush_q - 1'b1;
                end
            end
            ST_SETTLE: begin
                div_d = strobe ? rate_q : div_q - 1'b1;
                if (cic_g_out) begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                div_d = strobe ? rate_q : div_q - 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Disable beats a reconfiguration; a reconfiguration while active restarts the flush.
        if (state_q != ST_IDLE) begin
            if (!enable) begin
                state_d = ST_IDLE;
            end else if (cfg_stb) begin
                flush_entry = 1'b1;
            end
        end

        if (flush_entry) begin
            state_d = ST_FLUSH;
            flush_d = FLUSH_LOAD;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            rate_q   <= '0;
            div_q    <= '0;
            flush_q  <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            rate_q   <= rate_d;
            div_q    <= div_d;
            flush_q  <= flush_d;
            settle_q <= settle_d;
        end
    end

    // Outputs decode straight from registered state, no input-to-output paths.
    assign cic_reset = (state_q == ST_IDLE) || (state_q == ST_FLUSH);
    assign cic_g_in  = ((state_q == ST_SETTLE) || (state_q == ST_RUN)) && strobe;
    assign busy      = (state_q != ST_IDLE);

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    assign wr_idx     = wr_q[FIFO_AW-1:0];
    assign rd_idx     = rd_q[FIFO_AW-1:0];
    assign fifo_empty = (wr_q == rd_q);
    assign fifo_full  = (wr_q[FIFO_AW] != rd_q[FIFO_AW]) && (wr_idx == rd_idx);

    assign push_req = (state_q == ST_RUN) && cic_g_out;
    assign pop      = !fifo_empty && m_ready;
    // When full, a same-cycle pop frees the slot the push needs.
    assign push     = push_req && (!fifo_full || pop);
    assign drop     = push_req && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_idx] <= cic_d_out;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q      <= '0;
            rd_q      <= '0;
            hold_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (flush_entry) begin
                wr_q <= '0;
                rd_q <= '0;
            end else begin
                if (push) begin
                    wr_q <= wr_q + 1'b1;
                end
                if (pop) begin
                    rd_q <= rd_q + 1'b1;
                end
            end
            // Remember the last presented head so m_data is stable while empty.
            if (!fifo_empty) begin
                hold_q <= mem_q[rd_idx];
            end
            if (drop) begin
                overrun_q <= 1'b1;
            end else if (clr_overrun) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign m_valid = !fifo_empty;
    assign m_data  = fifo_empty ? hold_q : mem_q[rd_idx];
    assign overrun = overrun_q;

endmodule
